muldiv_seq: RTL

- Multi-cycle sequencer for MIPS MULT/MULTU/DIV/DIVU in the Execute stage.
- Drives one shared add/sub datapath through 32 shift-add or shift-subtract iterations.
- Writes HI/LO and holds busy so the hazard unit can stall the pipeline while an operation is in flight.

---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/muldiv_seq_alu.sv | 24 ++
 rtl/muldiv_seq.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the MULT/MULTU/DIV/DIVU sequencer and its add/sub step unit.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_seq_alu.sv
// Execute-stage ALU slice, used by the sequencer as its shared add/sub step unit.
module muldiv_seq_alu
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 33
) (
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);

  always_comb begin
    y_o = '0;
    case (ctrl_i)
      ALU_AND: y_o = a_i & b_i;
      ALU_OR:  y_o = a_i | b_i;
      ALU_ADD: y_o = a_i + b_i;
      ALU_SUB: y_o = a_i - b_i;
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer (shift-add multiply, restoring divide).
// Define MULDIV_EARLY_OUT_EN to let multiplies finish once the remaining multiplier bits are zero.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   acc_q, acc_d, sh_q, sh_d, m_q, m_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_a_q, neg_a_d, neg_b_q, neg_b_d, dbz_q, dbz_d;

  logic               is_div, is_signed;
  logic [WIDTH-1:0]   abs_a, abs_b, quo, rem;
  logic [2*WIDTH-1:0] raw_prod, prod;
  logic [WIDTH:0]     alu_a, alu_b, alu_y;
  logic [3:0]         alu_ctrl;

  assign is_div    = op_is_div(op_q);
  assign is_signed = op_is_signed(op_q);
  assign abs_a     = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
  assign abs_b     = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;

  // acc holds the running partial product / remainder, sh the multiplier / quotient.
  always_comb begin
    if (is_div) begin
      alu_a    = {acc_q, sh_q[WIDTH-1]};
      alu_b    = {1'b0, m_q};
      alu_ctrl = ALU_SUB;
    end else begin
      alu_a    = {1'b0, acc_q};
      alu_b    = sh_q[0] ? {1'b0, m_q} : '0;
      alu_ctrl = ALU_ADD;
    end
  end

  muldiv_seq_alu #(
    .WIDTH (WIDTH + 1)
  ) u_alu (
    .ctrl_i (alu_ctrl),
    .a_i    (alu_a),
    .b_i    (alu_b),
    .y_o    (alu_y)
  );

`ifdef MULDIV_EARLY_OUT_EN
  logic [WIDTH-1:0] early_mask;
  assign early_mask = (WIDTH'(1) << (cnt_q - 1'b1)) - 1'b1;
  // An early exit leaves cnt_q zero-add shifts undone; apply them here.
  assign raw_prod   = {acc_q, sh_q} >> cnt_q;
`else
  assign raw_prod   = {acc_q, sh_q};
`endif

  assign prod = (neg_a_q ^ neg_b_q) ? -raw_prod : raw_prod;
  assign quo  = (neg_a_q ^ neg_b_q) ? -sh_q : sh_q;
  assign rem  = neg_a_q ? -acc_q : acc_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    m_d     = m_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          dbz_d   = 1'b0;
          state_d = PREP;
        end
      end
      PREP: begin
        neg_a_d = is_signed & a_q[WIDTH-1];
        neg_b_d = is_signed & b_q[WIDTH-1];
        acc_d   = '0;
        sh_d    = is_div ? abs_a : abs_b;
        m_d     = is_div ? abs_b : abs_a;
        cnt_d   = CNT_W'(WIDTH);
        state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_q - 1'b1;
        if (is_div) begin
          // Restoring step: a negative trial keeps the shifted remainder.
          acc_d = alu_y[WIDTH] ? alu_a[WIDTH-1:0] : alu_y[WIDTH-1:0];
          sh_d  = {sh_q[WIDTH-2:0], ~alu_y[WIDTH]};
        end else begin
          acc_d = alu_y[WIDTH:1];
          sh_d  = {alu_y[0], sh_q[WIDTH-1:1]};
        end
        if (cnt_q == CNT_W'(1)) begin
          state_d = FIX;
        end
`ifdef MULDIV_EARLY_OUT_EN
        else if (!is_div && ((sh_d & early_mask) == '0)) begin
          state_d = FIX;
        end
`endif
      end
      FIX: begin
        if (!is_div) begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else if (b_q == '0) begin
          hi_d  = a_q;
          lo_d  = '1;
          dbz_d = 1'b1;
        end else begin
          hi_d = rem;
          lo_d = quo;
        end
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sh_q    <= '0;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      m_q     <= m_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule
